// File: rtl/inv_test_pkg.sv
// Shared definitions for the inverter stimulus/checker stage.
//   - state_e       : checker FSM states
//   - CNT_W_DEFAULT : default width of the error and vector counters
//   - NO_FAIL       : first_fail value meaning "no failing vector"
//   - LFSR_SEED/TAPS: 8-bit Fibonacci LFSR used when INV_STIM_CHECKER_LFSR_EN is defined
package inv_test_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StSample,
    StDone
  } state_e;

  localparam int unsigned CNT_W_DEFAULT = 8;
  localparam logic [CNT_W_DEFAULT-1:0] NO_FAIL = '1;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 map onto register bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous sense net.
// Ports:
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronised output, STAGES cycles behind d
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/inv_stim_checker.sv
// Stimulus/checker stage around a CMOS inverter cell. Drives a pattern onto
// the inverter input, waits settle_cycles plus the synchroniser depth, then
// compares the synchronised inverter output with the inverted drive value.
// Optional feature: define INV_STIM_CHECKER_LFSR_EN to take the pattern from
// bit 0 of an 8-bit LFSR (seed 8'hA5) instead of the alternating 0,1,0,1...
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin a run (only honoured in idle)
//   settle_cycles : extra wait cycles per vector, sampled when each vector is driven
//   drive         : to inverter input net
//   sense         : from inverter output net (asynchronous)
//   busy, done    : run in progress / one-cycle end-of-run pulse
//   pass          : run result, held until the next accepted start
//   err_count     : saturating mismatch count
//   first_fail    : index of first failing vector, all-ones if none
module inv_stim_checker
  import inv_test_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       settle_cycles,
  output logic             drive,
  input  logic             sense,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail
);

  localparam int unsigned WAIT_W = $clog2(15 + SYNC_STAGES + 1);

  state_e             state_q, state_d;
  logic               drive_q, drive_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   ff_q, ff_d;
  logic               pass_q, pass_d;
  logic               sense_sync;
  logic               pattern;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sense_sync (
    .clk(clk),
    .rst(rst),
    .d  (sense),
    .q  (sense_sync)
  );

`ifdef INV_STIM_CHECKER_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == StIdle && start) begin
      lfsr_d = LFSR_SEED;
    end else if (state_q == StSample) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  assign pattern = lfsr_q[0];
`else
  assign pattern = idx_q[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      drive_q <= 1'b0;
      wait_q  <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      ff_q    <= '1;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drive_q <= drive_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drive_d = drive_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    err_d   = err_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          ff_d    = '1;
          pass_d  = 1'b0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        drive_d = pattern;
        // The synchroniser depth is always added so settle_cycles=0 still
        // sees the new inverter output at the compare.
        wait_d  = WAIT_W'(settle_cycles) + WAIT_W'(SYNC_STAGES);
        state_d = StSettle;
      end
      StSettle: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q <= WAIT_W'(1)) begin
          state_d = StSample;
        end
      end
      StSample: begin
        // Healthy inverter: synchronised sense is the complement of drive.
        if (sense_sync == drive_q) begin
          if (err_q == '0) begin
            ff_d = idx_q;
          end
          if (err_q != '1) begin
            err_d = err_q + CNT_W'(1);
          end
        end
        if (idx_q == CNT_W'(NUM_VECTORS - 1)) begin
          pass_d  = (err_d == '0);
          state_d = StDone;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign drive      = drive_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_inv_stim_checker.sv
// Self-checking bench for inv_stim_checker. The inverter cell is replaced by
// a selectable sense model; expected results come from a vector table and a
// per-vector reference model built from the run rules. Honours
// INV_STIM_CHECKER_LFSR_EN for the pattern reference.
module tb_inv_stim_checker;
  import inv_test_pkg::*;

  localparam int NV = 16;
  localparam int SS = 2;
  localparam int CW = 8;

  // Sense models: 0 ideal inverter, 1 stuck at 0, 2 stuck at 1, 3 inverter with 3-cycle delay.
  localparam int MIdeal = 0, MStuck0 = 1, MStuck1 = 2, MDelay = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    settle_cycles = '0;
  logic          drive, sense, busy, done, pass;
  logic [CW-1:0] err_count, first_fail;
  logic [2:0]    dly = '0;
  int            mode = MIdeal;
  int            checks = 0;
  int            errors = 0;
  bit            prev_drive = 1'b0;  // drive level held when the next run begins

  typedef struct {
    int mode;
    int settle;
    bit spam;
    int exp_err;
    int exp_ff;
    bit exp_pass;
  } vec_t;

  vec_t tbl[8];

  inv_stim_checker #(
    .NUM_VECTORS(NV),
    .SYNC_STAGES(SS),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .settle_cycles(settle_cycles),
    .drive        (drive),
    .sense        (sense),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_fail   (first_fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dly <= {dly[1:0], drive};

  always_comb begin
    sense = 1'b0;
    case (mode)
      MIdeal:  sense = ~drive;
      MStuck0: sense = 1'b0;
      MStuck1: sense = 1'b1;
      default: sense = ~dly[2];
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pattern value of vector i, straight from the definition.
  function automatic bit pat(input int i);
`ifdef INV_STIM_CHECKER_LFSR_EN
    int r = 'hA5;
    for (int k = 0; k < i; k++) begin
      r = ((r << 1) & 255) | (((r >> 7) ^ (r >> 5) ^ (r >> 4) ^ (r >> 3)) & 1);
    end
    return bit'(r & 1);
`else
    return bit'(i % 2);
`endif
  endfunction

  // Reference result of one run. The delayed inverter is seen correctly only
  // when settle_cycles covers its delay; otherwise the checker sees the
  // complement of the previous drive level.
  task automatic model(input int m, input int s, input bit prev,
                       output int e, output int ff, output bit p);
    bit last = prev;
    e  = 0;
    ff = 255;
    for (int i = 0; i < NV; i++) begin
      bit d = pat(i);
      bit seen;
      case (m)
        MIdeal:  seen = ~d;
        MStuck0: seen = 1'b0;
        MStuck1: seen = 1'b1;
        default: seen = (s >= 3) ? ~d : ~last;
      endcase
      if (seen != ~d) begin
        if (ff == 255) ff = i;
        if (e < 255) e++;
      end
      last = d;
    end
    p = (e == 0);
  endtask

  // One complete run; c counts rising edges since the start edge.
  task automatic do_run(input string tag, input int m, input int s, input bit spam,
                        input int exp_e, input int exp_ff, input bit exp_p);
    int per = 2 + SS + s;
    int c = 0;
    int dones = 0;
    int done_c = -1;
    int got_e = -1, got_ff = -1, got_p = -1;
    logic [NV-1:0] seq = '0;
    logic [NV-1:0] exp_seq;
    for (int i = 0; i < NV; i++) exp_seq[i] = pat(i);
    mode = m;
    @(negedge clk);
    settle_cycles = 4'(s);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, " busy_after_start"}, int'(busy), 1);
    while (c < per * NV + 3) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (c % per == 2 && c / per < NV) seq[c/per] = drive;
      start = (spam && c < per * NV - 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (done) begin
        dones++;
        if (done_c < 0) begin
          done_c = c;
          got_e  = int'(err_count);
          got_ff = int'(first_fail);
          got_p  = int'(pass);
        end
      end
    end
    check({tag, " done_pulses"}, dones, 1);
    check({tag, " edges_to_done"}, done_c, per * NV);
    check({tag, " err_count"}, got_e, exp_e);
    check({tag, " first_fail"}, got_ff, exp_ff);
    check({tag, " pass"}, got_p, int'(exp_p));
    check({tag, " drive_seq"}, int'(seq), int'(exp_seq));
    check({tag, " busy_after_done"}, int'(busy), 0);
    check({tag, " pass_held"}, int'(pass), int'(exp_p));
    prev_drive = pat(NV - 1);
  endtask

  initial begin
    int e, ff;
    bit p;
    bit seen;
    int pre;

`ifdef INV_STIM_CHECKER_LFSR_EN
    begin
      bit pv = 1'b0;
      int ms[8] = '{MIdeal, MStuck0, MDelay, MDelay, MStuck1, MIdeal, MStuck0, MDelay};
      int st[8] = '{0, 0, 0, 3, 5, 15, 1, 2};
      bit sp[8] = '{0, 0, 0, 0, 0, 1, 1, 0};
      for (int i = 0; i < 8; i++) begin
        model(ms[i], st[i], pv, e, ff, p);
        tbl[i] = '{ms[i], st[i], sp[i], e, ff, p};
        pv = pat(NV - 1);
      end
    end
`else
    tbl[0] = '{MIdeal,  0,  1'b0, 0,  255, 1'b1};
    tbl[1] = '{MStuck0, 0,  1'b0, 8,  0,   1'b0};
    tbl[2] = '{MDelay,  0,  1'b0, 16, 0,   1'b0};
    tbl[3] = '{MDelay,  3,  1'b0, 0,  255, 1'b1};
    tbl[4] = '{MStuck1, 5,  1'b0, 8,  1,   1'b0};
    tbl[5] = '{MIdeal,  15, 1'b1, 0,  255, 1'b1};
    tbl[6] = '{MStuck0, 1,  1'b1, 8,  0,   1'b0};
    tbl[7] = '{MDelay,  2,  1'b0, 16, 0,   1'b0};
`endif

    // Reset values.
    #1 rst = 1'b1;
    #1;
    check("rst drive", int'(drive), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst pass", int'(pass), 0);
    check("rst err_count", int'(err_count), 0);
    check("rst first_fail", int'(first_fail), int'(NO_FAIL));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      do_run($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].settle, tbl[i].spam,
             tbl[i].exp_err, tbl[i].exp_ff, tbl[i].exp_pass);
    end

    // start held high through DONE: one idle cycle, then an immediate restart.
    mode = MIdeal;
    @(negedge clk);
    settle_cycles = 4'd0;
    start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    check("held done1", int'(seen), 1);
    @(negedge clk);
    check("held idle_gap busy", int'(busy), 0);
    @(negedge clk);
    check("held restart busy", int'(busy), 1);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    check("held done2", int'(seen), 1);
    check("held pass2", int'(pass), 1);
    prev_drive = pat(NV - 1);
    repeat (3) @(negedge clk);

    // Reset during vector 5 of a failing run.
    mode = MStuck0;
    settle_cycles = 4'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5 * 4 + 2) @(posedge clk);
    @(negedge clk);
    pre = 0;
    for (int i = 0; i < 5; i++) if (!pat(i)) pre++;
    check("midrst err_before", int'(err_count), pre);
    #2 rst = 1'b1;
    #1;
    check("midrst drive", int'(drive), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst pass", int'(pass), 0);
    check("midrst err_count", int'(err_count), 0);
    check("midrst first_fail", int'(first_fail), int'(NO_FAIL));
    seen = done;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | done;
    end
    check("midrst no_done", int'(seen), 0);
    prev_drive = 1'b0;
    do_run("post_rst", MIdeal, 0, 1'b0, 0, 255, 1'b1);

    // Randomised runs against the reference model.
    for (int r = 0; r < 10; r++) begin
      int m = $urandom_range(0, 3);
      int s = $urandom_range(0, 15);
      bit sp = 1'($urandom_range(0, 1));
      model(m, s, prev_drive, e, ff, p);
      do_run($sformatf("rnd%0d m%0d s%0d", r, m, s), m, s, sp, e, ff, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/inv_stim_checker.md
Name: inv_stim_checker

Overview:
- Digital stimulus/checker stage wrapped around the transistor-level CMOS inverter cell.
- Upstream role: drives the inverter input net with a test pattern.
- Downstream role: samples the inverter output net, compares it against the expected inverted value, and counts mismatches.
- Result and status are presented on dedicated 8-bit outputs for bench or pin readout.

Parameters:
- NUM_VECTORS, 16, vectors per run (2..255).
- SYNC_STAGES, 2, synchroniser depth on the sense input (>=2).
- CNT_W, 8, width of the error and vector counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- settle_cycles  in  4  extra wait cycles between drive change and sample.
- drive  out  1  to inverter input net.
- sense  in  1  from inverter output net; asynchronous.
- busy  out  1  high from accepted start until DONE exits.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  run result; held until next accepted start.
- err_count  out  CNT_W  saturating mismatch count.
- first_fail  out  CNT_W  index of first failing vector; all-ones if none.

Behaviour:
- Reset values (async, immediate): state=IDLE, drive=0, busy=0, done=0, pass=0, err_count=0, first_fail=all-ones, vector index=0, synchroniser flops=0.
- sense passes through a SYNC_STAGES flop chain; only the synchronised value is compared.
- FSM states:
  - IDLE: start=1 -> clear err_count/first_fail/index, pass=0, busy=1 -> DRIVE.
  - DRIVE (1 cycle): drive <= pattern(index); load wait counter with settle_cycles+SYNC_STAGES -> SETTLE.
  - SETTLE: decrement each cycle; at 0 -> SAMPLE. settle_cycles=0 still waits SYNC_STAGES cycles.
  - SAMPLE (1 cycle): expected = ~drive.
    - Mismatch: err_count += 1, saturating at 2^CNT_W-1; if first mismatch, first_fail <= index.
    - index == NUM_VECTORS-1 -> DONE; else index+1 -> DRIVE.
  - DONE (1 cycle): done=1, pass=(err_count==0), busy=0 on exit -> IDLE.
- Default pattern: pattern(i) = i[0], i.e. 0,1,0,1...; vector 0 drives 0.
- Per-vector latency: 1 + settle_cycles + SYNC_STAGES + 1 cycles.
- Total run: NUM_VECTORS * per-vector latency + 1 (DONE) cycles after the start edge.
- start while busy: ignored, no restart.
- start held high through DONE: a new run starts on the first IDLE cycle.
- settle_cycles is sampled at each DRIVE only; mid-run changes apply to the next vector.
- drive holds its last value in IDLE/DONE.
- rst mid-run: everything returns to reset values; no done pulse; partial results discarded.

Optional Feature:
- Macro: INV_STIM_CHECKER_LFSR_EN.
- Defined: pattern(i) = bit 0 of an 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5.
  - Seed reloads on accepted start.
  - LFSR advances once per SAMPLE.
- Undefined: alternating pattern only; no LFSR logic synthesised.

Decomposition:
- Shared package inv_test_pkg holds:
  - state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE)
  - LFSR seed and tap constants
  - CNT_W default
  - the all-ones "no fail" constant
- One natural sub-module: sync_chain (parameterised SYNC_STAGES flop synchroniser), also reusable for other analog sense nets.

Test Plan:
- Ideal inverter model (sense = ~drive), settle=0, start pulse:
  - done pulses once, pass=1, err_count=0, first_fail=8'hFF.
  - Total 16*4+1=65 cycles from start.
- sense stuck at 0: vectors 0,2,4... mismatch -> err_count=8, first_fail=0, pass=0.
- Inverter model with 3-cycle delay:
  - settle=0 -> mismatches on every vector (err_count=16).
  - settle=3 -> pass=1.
- Assert start repeatedly mid-run: single run, one done pulse; err_count identical to a clean run.
- Assert rst at vector 5:
  - all outputs return to reset values immediately; no done pulse.
  - A following start completes normally.
- With INV_STIM_CHECKER_LFSR_EN, ideal model: drive sequence matches the reference LFSR bit0 from seed 8'hA5; pass=1.
